// File: rtl/snake_pkg.sv
// Shared command encodings and default timing constants for the game input stage.
package snake_pkg;

   typedef logic [1:0] ctrl_t;

   localparam ctrl_t CTRL_KEY0 = 2'b00;
   localparam ctrl_t CTRL_KEY1 = 2'b01;
   localparam ctrl_t CTRL_KEY2 = 2'b10;
   localparam ctrl_t CTRL_NONE = 2'b11;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_FIFO_DEPTH      = 4;
   localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/key_debouncer.sv
// One raw active-low key: 2-flop synchronizer, debounce counter, stable level, press pulse.
// Optional auto-repeat counter under `KEY_REPEAT_EN.
module key_debouncer
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic OSC_50,
   input  logic rst,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          raw_pressed;

   assign raw_pressed = ~sync_q[1];

`ifdef KEY_REPEAT_EN
   localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   logic [RW-1:0] rep_q, rep_d;
`else
   logic rep_unused;
   assign rep_unused = (REPEAT_CYCLES != 0);
`endif

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (raw_pressed != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = raw_pressed;
            press_d = raw_pressed;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`ifdef KEY_REPEAT_EN
      // Period counts from the edge where the stable level went pressed.
      rep_d = '0;
      if (level_q) begin
         if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
            press_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge OSC_50 or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         sync_q  <= {sync_q[0], key_n_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
`ifdef KEY_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/turn_command_buffer.sv
// Debounced keys -> priority-encoded turn commands -> FIFO released one per game tick.
// Auto-repeat of held keys is enabled with `KEY_REPEAT_EN.
module turn_command_buffer
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
   parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic                        OSC_50,
   input  logic                        rst,
   input  logic [2:0]                  key_n,
   input  logic                        tick,
   output ctrl_t                       control,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic [2:0]                  key_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [2:0] press;

   for (genvar i = 0; i < 3; i++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_deb (
         .OSC_50  (OSC_50),
         .rst     (rst),
         .key_n_i (key_n[i]),
         .level_o (key_level[i]),
         .press_o (press[i])
      );
   end

   ctrl_t          mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]  level_q, level_d;
   ctrl_t          control_q, control_d;
   logic           ovf_q, ovf_d;
   ctrl_t          push_code;
   logic           push, push_ok, pop, empty, full, collision;

   always_comb begin
      push_code = CTRL_NONE;
      if (press[0])      push_code = CTRL_KEY0;
      else if (press[1]) push_code = CTRL_KEY1;
      else if (press[2]) push_code = CTRL_KEY2;
      push      = |press;
      collision = (press & (press - 3'd1)) != 3'd0;
      empty     = (level_q == '0);
      full      = (level_q == LW'(FIFO_DEPTH));
      // A pop is resolved before the push, so a full FIFO still accepts on a tick.
      pop       = tick && !empty;
      push_ok   = push && (!full || pop);

      control_d = control_q;
      if (tick) control_d = empty ? CTRL_NONE : mem_q[rd_q];

      wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      level_d = level_q;
      if (push_ok && !pop)      level_d = level_q + 1'b1;
      else if (!push_ok && pop) level_d = level_q - 1'b1;

      ovf_d = ovf_q | collision | (push && !push_ok);
   end

   always_ff @(posedge OSC_50) begin
      if (push_ok) mem_q[wr_q] <= push_code;
   end

   always_ff @(posedge OSC_50 or posedge rst) begin
      if (rst) begin
         wr_q      <= '0;
         rd_q      <= '0;
         level_q   <= '0;
         control_q <= CTRL_NONE;
         ovf_q     <= 1'b0;
      end else begin
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         level_q   <= level_d;
         control_q <= control_d;
         ovf_q     <= ovf_d;
      end
   end

   assign control    = control_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_turn_command_buffer.sv
// Directed + randomized bench for turn_command_buffer against a queue-based behavioural model.
// Build with or without KEY_REPEAT_EN; expectations follow the macro.
module tb_turn_command_buffer;
   import snake_pkg::*;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;
   localparam int REP   = 20;
   localparam int MAXE  = 4096;

   logic       OSC_50 = 1'b0;
   logic       rst    = 1'b1;
   logic [2:0] key_n  = 3'b111;
   logic       tick   = 1'b0;
   ctrl_t      control;
   logic [2:0] fifo_level;
   logic       overflow;
   logic [2:0] key_level;

   always #5 OSC_50 = ~OSC_50;

   turn_command_buffer #(
      .DEBOUNCE_CYCLES (DEB),
      .FIFO_DEPTH      (DEPTH),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .OSC_50     (OSC_50),
      .rst        (rst),
      .key_n      (key_n),
      .tick       (tick),
      .control    (control),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .key_level  (key_level)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int edge_cnt = 0;

   // Model: debounced level changes are scheduled by the stimulus (5 edges after the raw
   // change is first sampled); a press event is pushed the edge after a level rises.
   ctrl_t    mq[$];
   ctrl_t    exp_ctrl = CTRL_NONE;
   bit       exp_ovf  = 1'b0;
   bit [2:0] exp_lvl  = 3'b000;
   int       since[3];
   bit [2:0] ev[MAXE];
   bit [2:0] lvl_on[MAXE];
   bit [2:0] lvl_off[MAXE];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_ctrl = CTRL_NONE;
      exp_ovf  = 1'b0;
      exp_lvl  = 3'b000;
      for (int k = 0; k < 3; k++) since[k] = 0;
      for (int e = edge_cnt + 1; e < MAXE; e++) begin
         ev[e] = 3'b000; lvl_on[e] = 3'b000; lvl_off[e] = 3'b000;
      end
   endtask

   task automatic model_edge();
      bit [2:0] evs;
      edge_cnt++;
      if (rst) begin
         model_reset();
         return;
      end
      if (edge_cnt + 1 >= MAXE) return;
      if (tick) exp_ctrl = (mq.size() != 0) ? mq.pop_front() : CTRL_NONE;
      evs = ev[edge_cnt];
      if (evs != 3'b000) begin
         if ($countones(evs) > 1) exp_ovf = 1'b1;
         if (mq.size() < DEPTH)
            mq.push_back(evs[0] ? CTRL_KEY0 : (evs[1] ? CTRL_KEY1 : CTRL_KEY2));
         else
            exp_ovf = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         if (exp_lvl[k]) begin
            since[k]++;
`ifdef KEY_REPEAT_EN
            if (since[k] % REP == 0) ev[edge_cnt + 1][k] = 1'b1;
`endif
         end
         if (lvl_on[edge_cnt][k]) begin
            exp_lvl[k] = 1'b1;
            since[k]   = 0;
            ev[edge_cnt + 1][k] = 1'b1;
         end
         if (lvl_off[edge_cnt][k]) exp_lvl[k] = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("control",    32'(control),    32'(exp_ctrl));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("overflow",   32'(overflow),   32'(exp_ovf));
      chk("key_level",  32'(key_level),  32'(exp_lvl));
   endtask

   task automatic cycle();
      @(posedge OSC_50);
      #1;
      model_edge();
      check_all();
      tick = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // Clean key transition, first sampled on the next edge.
   task automatic set_key(input int k, input bit pressed);
      key_n[k] = ~pressed;
      if (edge_cnt + 6 < MAXE) begin
         if (pressed) lvl_on[edge_cnt + 6][k]  = 1'b1;
         else         lvl_off[edge_cnt + 6][k] = 1'b1;
      end
   endtask

   task automatic tap(input int k);
      set_key(k, 1'b1); run(8);
      set_key(k, 1'b0); run(8);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_control",  32'(control),    32'(CTRL_NONE));
      chk("rst_level",    32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow),   32'd0);
      chk("rst_keylevel", 32'(key_level),  32'd0);
      run(n);
      rst = 1'b0;
      for (int k = 0; k < 3; k++)
         if (key_n[k] == 1'b0) lvl_on[edge_cnt + 6][k] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int hold[3];
      int gap[3];
      int exp_rep;

      // Power-up reset
      run(3);
      rst = 1'b0;
      run(3);
      chk("init_control", 32'(control), 32'(CTRL_NONE));
      chk("init_level",   32'(fifo_level), 32'd0);

      // Single press of key1: level 1 exactly 7 edges after the raw edge
      set_key(1, 1'b1);
      run(6);
      chk("single_pre7", 32'(fifo_level), 32'd0);
      run(1);
      chk("single_at7",  32'(fifo_level), 32'd1);
      run(3);
      set_key(1, 1'b0);
      run(10);
      tick = 1'b1; cycle();
      chk("single_ctrl", 32'(control), 32'(CTRL_KEY1));
      chk("single_drain", 32'(fifo_level), 32'd0);
      run(2);
      tick = 1'b1; cycle();
      chk("single_none", 32'(control), 32'(CTRL_NONE));

      // Bounce on key0 every 2 cycles, never stable long enough
      for (int i = 0; i < 10; i++) begin
         key_n[0] = ~key_n[0];
         run(2);
      end
      run(10);
      chk("bounce_level", 32'(fifo_level), 32'd0);
      chk("bounce_keys",  32'(key_level),  32'd0);

      // Five presses with no tick: fifth dropped
      tap(0); tap(1); tap(2); tap(0); tap(1);
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_flag",  32'(overflow),   32'd1);
      tick = 1'b1; cycle(); chk("ovf_pop0", 32'(control), 32'(CTRL_KEY0)); run(1);
      tick = 1'b1; cycle(); chk("ovf_pop1", 32'(control), 32'(CTRL_KEY1)); run(1);
      tick = 1'b1; cycle(); chk("ovf_pop2", 32'(control), 32'(CTRL_KEY2)); run(1);
      tick = 1'b1; cycle(); chk("ovf_pop3", 32'(control), 32'(CTRL_KEY0)); run(1);
      tick = 1'b1; cycle(); chk("ovf_pop4", 32'(control), 32'(CTRL_NONE));

      // Reset mid-stream with one entry queued and key0 held through reset
      tap(1);
      set_key(0, 1'b1);
      run(3);
      do_reset(2);
      run(6);
      chk("rst_held_pre", 32'(fifo_level), 32'd0);
      run(1);
      chk("rst_held_push", 32'(fifo_level), 32'd1);
      set_key(0, 1'b0);
      run(8);
      tick = 1'b1; cycle();
      chk("rst_held_ctrl", 32'(control), 32'(CTRL_KEY0));

      // Simultaneous key0 + key2
      do_reset(1);
      set_key(0, 1'b1); set_key(2, 1'b1);
      run(10);
      set_key(0, 1'b0); set_key(2, 1'b0);
      run(8);
      chk("simul_level", 32'(fifo_level), 32'd1);
      chk("simul_ovf",   32'(overflow),   32'd1);
      tick = 1'b1; cycle();
      chk("simul_ctrl",  32'(control), 32'(CTRL_KEY0));

      // Full FIFO: tick and push on the same edge
      do_reset(1);
      tap(2); tap(1); tap(0); tap(2);
      set_key(1, 1'b1);
      run(6);
      tick = 1'b1; cycle();
      chk("full_tp_level", 32'(fifo_level), 32'd4);
      chk("full_tp_ctrl",  32'(control),    32'(CTRL_KEY2));
      chk("full_tp_ovf",   32'(overflow),   32'd0);
      set_key(1, 1'b0);
      run(8);
      repeat (5) begin tick = 1'b1; cycle(); end

      // Key2 held 50 cycles past debounce
      do_reset(1);
      set_key(2, 1'b1);
      run(50);
      set_key(2, 1'b0);
      run(10);
`ifdef KEY_REPEAT_EN
      exp_rep = 3;
`else
      exp_rep = 1;
`endif
      chk("repeat_pushes", 32'(fifo_level), 32'(exp_rep));
      repeat (4) begin tick = 1'b1; cycle(); end

      // Randomized presses and ticks
      do_reset(1);
      for (int k = 0; k < 3; k++) begin hold[k] = 0; gap[k] = 8; end
      for (int i = 0; i < 900; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (hold[k] > 0) begin
               hold[k]--;
               if (hold[k] == 0) begin
                  set_key(k, 1'b0);
                  gap[k] = 8 + int'($urandom_range(0, 6));
               end
            end else if (gap[k] > 0) begin
               gap[k]--;
            end else if ($urandom_range(0, 11) == 0) begin
               set_key(k, 1'b1);
               hold[k] = int'($urandom_range(7, 12));
            end
         end
         tick = ($urandom_range(0, 3) == 0);
         cycle();
      end
      for (int k = 0; k < 3; k++) if (key_n[k] == 1'b0) set_key(k, 1'b0);
      run(12);
      repeat (6) begin tick = 1'b1; cycle(); end
      chk("final_empty", 32'(fifo_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
